gfx_line_engine: RTL
====================

# gfx_line_engine

Hardware line rasterizer on the CPU's checkpoint-3 line command interface. The processor writes endpoint coordinates and a colour through single-cycle valid strobes, then pulses a trigger. The engine runs integer Bresenham and emits one pixel per handshake toward the frame-buffer writer. It is the responder for the `line_*` outputs and the `line_ready` input of the processor top level.

## Interface
Parameters:
- `CW`, 10: coordinate width (matches `line_point`).
- `EW`, 12: signed Bresenham error-term width; must be ≥ `CW`+2.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `line_color`  in  32: colour word; bits [23:0] used, [31:24] ignored.
- `line_point`  in  `CW`: coordinate value for the x/y strobes.
- `line_color_valid`  in  1: latch `line_color` into the colour register.
- `line_x0_valid`, `line_y0_valid`, `line_x1_valid`, `line_y1_valid`  in  1 each: latch `line_point` into the named endpoint register.
- `line_trigger`  in  1: start drawing the latched line.
- `line_ready`  out  1: engine idle; strobes and trigger accepted.
- `pix_valid`  out  1: pixel presented.
- `pix_ready`  in  1: downstream accepts the pixel.
- `pix_x`, `pix_y`  out  `CW` each: pixel coordinate, unsigned.
- `pix_color`  out  24: pixel colour.

## Operation
- Registers: X0, Y0, X1, Y1, COLOR. Each loads on its strobe only while `line_ready`=1. Strobes while busy are ignored.
- States:
  - IDLE: `line_ready`=1. `line_trigger` → SETUP1.
  - SETUP1: reads the registers, so a strobe in the trigger cycle is used. Computes steep = |Y1−Y0| > |X1−X0|. If steep, swaps x↔y on both endpoints into working regs. → SETUP2.
  - SETUP2: if wx0 > wx1, swaps the endpoints. Then:
    - dx = wx1−wx0.
    - dy = |wy1−wy0|.
    - err = dx>>1 (signed `EW`).
    - ystep = +1 if wy0<wy1, else −1.
    - cx=wx0, cy=wy0.
    - → DRAW.
  - DRAW: `pix_valid`=1. Output {`pix_x`,`pix_y`} = steep ? {cy,cx} : {cx,cy}. On `pix_valid`&`pix_ready`:
    - if cx==wx1 → IDLE.
    - else cx+1, e=err−dy; if e<0 then cy+=ystep and err=e+dx, else err=e.
- `pix_color` = COLOR[23:0], held constant for the whole line.
- Pixel count is max(|dx|,|dy|)+1. Emission order runs from the lower major-axis coordinate to the higher, regardless of the order the endpoints were written.
- Degenerate line (both endpoints equal): exactly one pixel.
- `line_trigger` while busy is ignored.
- Arithmetic: deltas are `CW`+1-bit signed. cx/cy never leave the [min,max] endpoint range, so they do not wrap.

## Timing
- Reset values: state IDLE; `line_ready`=1 from the first cycle after reset; `pix_valid`=0; X0,Y0,X1,Y1,COLOR=0; `pix_x`,`pix_y`,`pix_color`=0.
- Trigger sampled at edge T:
  - `line_ready`=0 from T+1.
  - First `pix_valid` at T+3 (SETUP1, SETUP2, then DRAW).
- Throughput is one pixel per cycle while `pix_ready`=1.
- `pix_valid` and `pix_x`/`pix_y`/`pix_color` hold stable while `pix_ready`=0. `pix_valid` never drops without a handshake, except on reset.
- After the final handshake at edge E: `pix_valid`=0 and `line_ready`=1 from E+1. A new trigger is accepted at E+1.
- Reset mid-line: drawing aborts. IDLE, `pix_valid`=0 and `line_ready`=1 the cycle after `rst`. Registers are cleared.

## Test plan
- Horizontal line:
  - Stimulus: strobe X0=0, Y0=0, X1=3, Y1=0, COLOR=0x00FF00AA, trigger, `pix_ready`=1.
  - Response: pixels (0,0),(1,0),(2,0),(3,0) on consecutive cycles, first at trigger+3; `pix_color`=0xFF00AA; `line_ready`=1 the cycle after the last pixel.
- Steep, reversed endpoints:
  - Stimulus: X0=2, Y0=5, X1=0, Y1=0.
  - Response: exactly (0,0),(0,1),(1,2),(1,3),(2,4),(2,5).
- Backpressure:
  - Stimulus: the horizontal line above, with `pix_ready` toggling 1,0,0,1,….
  - Response: each pixel held stable through stall cycles; no duplicates or drops; 4 handshakes total.
- Single point and same-cycle strobe:
  - Stimulus: X0=X1=7 and Y0=9 pre-loaded; Y1=9 strobed in the same cycle as the trigger.
  - Response: exactly one pixel (7,9).
- Busy-time writes:
  - Stimulus: during a line, strobe X1=500 and pulse the trigger.
  - Response: the current line is unaffected; no second line follows; X1 keeps its old value.
- Reset mid-line:
  - Stimulus: assert `rst` for 1 cycle after the 2nd pixel of a 10-pixel line.
  - Response: `pix_valid`=0 and `line_ready`=1 the next cycle; no further pixels; registers read 0.

Source files
------------

// File: rtl/gfx_line_engine.sv
// Bresenham line rasterizer: latches endpoints and colour from CPU strobes, then
// streams one pixel per valid/ready handshake toward the frame-buffer writer.
module gfx_line_engine #(
  parameter int CW = 10,
  parameter int EW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   line_color,
  input  logic [CW-1:0] line_point,
  input  logic          line_color_valid,
  input  logic          line_x0_valid,
  input  logic          line_y0_valid,
  input  logic          line_x1_valid,
  input  logic          line_y1_valid,
  input  logic          line_trigger,
  output logic          line_ready,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [23:0]   pix_color
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP1, S_SETUP2, S_DRAW} state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_pix_valid;
  logic [CW-1:0]         r_pix_x, r_pix_y;
  logic [CW-1:0]         r_x0, r_y0, r_x1, r_y1;
  logic [23:0]           r_color;
  logic                  r_steep;
  logic [CW-1:0]         r_wx0, r_wy0, r_wx1, r_wy1;
  logic [CW-1:0]         r_cx, r_cy;
  logic signed [EW-1:0]  r_dx, r_dy, r_err;
  logic                  r_ydec;

  // |a-b| computed on CW+1-bit signed deltas so the full coordinate range is safe
  function automatic logic [CW-1:0] abs_delta(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic signed [CW:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    if (d < 0) d = -d;
    return d[CW-1:0];
  endfunction

  function automatic logic signed [EW-1:0] widen(input logic [CW-1:0] v);
    return $signed({{(EW-CW){1'b0}}, v});
  endfunction

  logic                 w_unused_color;
  logic [CW-1:0]        w_adx, w_ady;
  logic                 w_steep;
  logic                 w_swap;
  logic [CW-1:0]        w_sx0, w_sy0, w_sx1, w_sy1;
  logic [CW-1:0]        w_dxu;
  logic signed [EW-1:0] w_dx, w_dy;
  logic signed [EW-1:0] w_e, w_nerr;
  logic                 w_last;
  logic [CW-1:0]        w_ncx, w_ncy;

  assign w_unused_color = &line_color[31:24];

  // SETUP1: steepness from the latched endpoints
  assign w_adx   = abs_delta(r_x1, r_x0);
  assign w_ady   = abs_delta(r_y1, r_y0);
  assign w_steep = w_ady > w_adx;

  // SETUP2: order the working endpoints so the major axis always increments
  assign w_swap = r_wx0 > r_wx1;
  assign w_sx0  = w_swap ? r_wx1 : r_wx0;
  assign w_sy0  = w_swap ? r_wy1 : r_wy0;
  assign w_sx1  = w_swap ? r_wx0 : r_wx1;
  assign w_sy1  = w_swap ? r_wy0 : r_wy1;
  assign w_dxu  = w_sx1 - w_sx0;
  assign w_dx   = widen(w_dxu);
  assign w_dy   = widen(abs_delta(w_sy1, w_sy0));

  // DRAW: next Bresenham step
  assign w_last = (r_cx == r_wx1);
  assign w_e    = r_err - r_dy;
  assign w_ncx  = r_cx + CW'(1);
  assign w_ncy  = (w_e < 0) ? (r_ydec ? r_cy - CW'(1) : r_cy + CW'(1)) : r_cy;
  assign w_nerr = (w_e < 0) ? w_e + r_dx : w_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_pix_valid <= 1'b0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_color     <= '0;
      r_steep     <= 1'b0;
      r_wx0       <= '0;
      r_wy0       <= '0;
      r_wx1       <= '0;
      r_wy1       <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_ydec      <= 1'b0;
    end else begin
      if (r_ready) begin
        if (line_color_valid) r_color <= line_color[23:0];
        if (line_x0_valid)    r_x0    <= line_point;
        if (line_y0_valid)    r_y0    <= line_point;
        if (line_x1_valid)    r_x1    <= line_point;
        if (line_y1_valid)    r_y1    <= line_point;
      end
      case (r_state)
        S_IDLE: begin
          if (line_trigger) begin
            r_state <= S_SETUP1;
            r_ready <= 1'b0;
          end
        end
        S_SETUP1: begin
          r_steep <= w_steep;
          r_wx0   <= w_steep ? r_y0 : r_x0;
          r_wy0   <= w_steep ? r_x0 : r_y0;
          r_wx1   <= w_steep ? r_y1 : r_x1;
          r_wy1   <= w_steep ? r_x1 : r_y1;
          r_state <= S_SETUP2;
        end
        S_SETUP2: begin
          r_wx1       <= w_sx1;
          r_wy1       <= w_sy1;
          r_dx        <= w_dx;
          r_dy        <= w_dy;
          r_err       <= w_dx >>> 1;
          r_ydec      <= !(w_sy0 < w_sy1);
          r_cx        <= w_sx0;
          r_cy        <= w_sy0;
          r_pix_x     <= r_steep ? w_sy0 : w_sx0;
          r_pix_y     <= r_steep ? w_sx0 : w_sy0;
          r_pix_valid <= 1'b1;
          r_state     <= S_DRAW;
        end
        S_DRAW: begin
          if (pix_ready) begin
            if (w_last) begin
              r_pix_valid <= 1'b0;
              r_ready     <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
              r_cx    <= w_ncx;
              r_cy    <= w_ncy;
              r_err   <= w_nerr;
              r_pix_x <= r_steep ? w_ncy : w_ncx;
              r_pix_y <= r_steep ? w_ncx : w_ncy;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign line_ready = r_ready;
  assign pix_valid  = r_pix_valid;
  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign pix_color  = r_color;

endmodule
